// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//  - FSM state encodings (kept as fixed 2-bit codes so existing waveforms
//    and debug scripts keep decoding the state register the same way)
//  - default sequential PC increment for a word-addressed instruction memory
package instr_fetch_ctrl_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  localparam int unsigned PC_INC_DEFAULT = 1;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller wrapped around an external PC register.
// Presents pc_cur to instruction memory (req/ack), captures the returned word,
// hands it to decode (valid/ready), then strobes next-PC into the PC register.
// Branch redirects from execute are latched here and applied on the next
// PC update.
// Ports:
//  clk, reset             clock; asynchronous active-low reset
//  pc_cur / pc_next       PC register output / data input
//  pc_update              one-cycle PC register load strobe
//  branch_taken/_target   redirect request and address from execute
//  halt                   block entry into a new fetch
//  imem_req/addr/ack/rdata instruction memory handshake
//  instr/instr_pc/instr_valid/instr_ready  decode handshake
//  busy                   controller not idle
import instr_fetch_ctrl_pkg::*;

module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_INC  = PC_INC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_update,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic              redirect;

  // A branch seen this very cycle counts the same as one already latched.
  assign redirect = redir_pend | branch_taken;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (redirect)   state_nxt = UPDATE;
        else if (!halt) state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack) state_nxt = redirect ? UPDATE : HOLD;
      end
      HOLD: begin
        if (branch_taken || instr_ready) state_nxt = UPDATE;
      end
      UPDATE: begin
        state_nxt = halt ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      redir_pend  <= 1'b0;
      redir_addr  <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      // A branch arriving during UPDATE must survive the clear so that it is
      // applied on the following UPDATE; hence set takes priority over clear.
      if (branch_taken) begin
        redir_pend <= 1'b1;
        redir_addr <= branch_target;
      end else if (state == UPDATE) begin
        redir_pend <= 1'b0;
      end

      if (state == FETCH && imem_ack && !redirect) begin
        instr       <= imem_rdata;
        instr_pc    <= pc_cur;
        instr_valid <= 1'b1;
      end else if (state == HOLD && (branch_taken || instr_ready)) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // By the time UPDATE is reached, any branch from the entering cycle has
  // already been latched into redir_pend/redir_addr.
  always_comb begin
    pc_update = (state == UPDATE);
    pc_next   = '0;
    if (pc_update) pc_next = redir_pend ? redir_addr : pc_cur + ADDR_W'(PC_INC);
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = imem_req ? pc_cur : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_update;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;

  logic        force_pc;
  logic [31:0] force_val;
  int unsigned ack_delay;
  int unsigned ack_cnt;

  exp_instr_t  instr_q[$];
  logic [31:0] pcn_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .PC_INC(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .pc_update     (pc_update),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // PC register model, with a bench-side load port for positioning the PC.
  always @(posedge clk or negedge reset) begin
    if (!reset)         pc_cur <= '0;
    else if (force_pc)  pc_cur <= force_val;
    else if (pc_update) pc_cur <= pc_next;
  end

  // Instruction memory model: ack after ack_delay waiting cycles (0 = same cycle).
  always @(posedge clk or negedge reset) begin
    if (!reset)                     ack_cnt <= 0;
    else if (imem_req && !imem_ack) ack_cnt <= ack_cnt + 1;
    else                            ack_cnt <= 0;
  end
  assign imem_ack   = imem_req && (ack_cnt >= ack_delay);
  assign imem_rdata = 32'hA5A5_0001 + imem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an output.
  always @(negedge clk) begin : monitor
    exp_instr_t e;
    logic [31:0] p;
    if (reset) begin
      if (instr_valid && instr_ready && !branch_taken) begin
        if (instr_q.size() == 0) begin
          check("unexpected_instr_accept", {31'b0, instr_valid}, 32'd0);
        end else begin
          e = instr_q.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, e.pc);
        end
      end
      if (pc_update) begin
        if (pcn_q.size() == 0) begin
          check("unexpected_pc_update", {31'b0, pc_update}, 32'd0);
        end else begin
          p = pcn_q.pop_front();
          check("pc_next", pc_next, p);
        end
      end
    end
  end

  task automatic kick();
    @(posedge clk); #1 halt = 1'b0;
    @(posedge clk); #1 halt = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(posedge clk); #1 force_val = v; force_pc = 1'b1;
    @(posedge clk); #1 force_pc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; halt = 1'b1; instr_ready = 1'b1; branch_taken = 1'b0;
    branch_target = '0; force_pc = 1'b0; force_val = '0; ack_delay = 0;

    // Reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc_update", {31'b0, pc_update}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("idle_halted_busy", {31'b0, busy}, 32'd0);

    // 1: zero-wait fetch at PC 0
    instr_q.push_back('{32'hA5A5_0001, 32'd0}); pcn_q.push_back(32'd1);
    kick();
    wait_idle();

    // 2: ack delayed 3 cycles, fetch at PC 1
    ack_delay = 3;
    instr_q.push_back('{32'hA5A5_0002, 32'd1}); pcn_q.push_back(32'd2);
    kick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_imem_req", {31'b0, imem_req}, 32'd1);
      check("t2_imem_addr", imem_addr, 32'd1);
      check("t2_no_pc_update", {31'b0, pc_update}, 32'd0);
      check("t2_no_valid", {31'b0, instr_valid}, 32'd0);
    end
    wait_idle();

    // 3: decode stalls 4 cycles in HOLD
    ack_delay = 0; instr_ready = 1'b0;
    instr_q.push_back('{32'hA5A5_0003, 32'd2}); pcn_q.push_back(32'd3);
    kick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_valid", {31'b0, instr_valid}, 32'd1);
      check("t3_instr", instr, 32'hA5A5_0003);
      check("t3_instr_pc", instr_pc, 32'd2);
      check("t3_no_pc_update", {31'b0, pc_update}, 32'd0);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    wait_idle();

    // 4: branch during FETCH at PC 5 discards the ack data
    set_pc(32'd5);
    ack_delay = 2;
    pcn_q.push_back(32'h40);
    kick();
    branch_taken = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    check("t4_imem_addr", imem_addr, 32'd5);
    @(posedge clk); #1 branch_taken = 1'b0;
    wait_idle();
    ack_delay = 0;
    instr_q.push_back('{32'hA5A5_0041, 32'h40}); pcn_q.push_back(32'h41);
    kick();
    @(negedge clk);
    check("t4_refetch_addr", imem_addr, 32'h40);
    wait_idle();

    // 5: branch together with instr_ready in HOLD squashes the instruction
    instr_ready = 1'b0;
    pcn_q.push_back(32'h80);
    kick();
    @(posedge clk); #1 instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    @(negedge clk);
    check("t5_valid_in_hold", {31'b0, instr_valid}, 32'd1);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    check("t5_valid_dropped", {31'b0, instr_valid}, 32'd0);
    check("t5_in_update", {31'b0, pc_update}, 32'd1);
    wait_idle();

    // 5b: sequential increment wraps at the top of the address space
    set_pc(32'hFFFF_FFFF);
    instr_q.push_back('{32'hA5A5_0000, 32'hFFFF_FFFF}); pcn_q.push_back(32'd0);
    kick();
    wait_idle();

    // 6: halt held through HOLD -> UPDATE -> IDLE
    instr_ready = 1'b0;
    instr_q.push_back('{32'hA5A5_0001, 32'd0}); pcn_q.push_back(32'd1);
    kick();
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk);
    check("t6_busy_hold", {31'b0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t6_update_pulse", {31'b0, pc_update}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t6_idle_busy", {31'b0, busy}, 32'd0);
    check("t6_idle_req", {31'b0, imem_req}, 32'd0);

    // 6b: asynchronous reset while a fetch is outstanding
    ack_delay = 5;
    kick();
    @(negedge clk);
    check("t6_req_before_reset", {31'b0, imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_req", {31'b0, imem_req}, 32'd0);
    check("t6_async_busy", {31'b0, busy}, 32'd0);
    check("t6_async_addr", imem_addr, 32'd0);
    #20 reset = 1'b1;
    @(negedge clk);
    check("t6_post_reset_idle", {31'b0, busy}, 32'd0);

    check("instr_q_drained", instr_q.size(), 32'd0);
    check("pcn_q_drained", pcn_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
